// File: rtl/seq_detect_pkg.sv
// Shared helpers for the serial pattern detector: state sizing and the
// elaboration-time KMP transition functions.
package seq_detect_pkg;

    localparam int MAX_PATTERN_W = 16;

    typedef enum logic {
        MODE_RESTART = 1'b0,
        MODE_OVERLAP = 1'b1
    } mode_e;

    function automatic int state_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

    // Bit i of the pattern in arrival order (i = 0 is the first bit received).
    function automatic logic pat_bit(input logic [15:0] pattern, input int width, input int i);
        logic [15:0] sh;
        sh = pattern >> (width - 1 - i);
        return sh[0];
    endfunction

    // Longest pattern prefix (shorter than the whole pattern) that ends the
    // string "first <state> pattern bits followed by b".
    function automatic int fail_next(input logic [15:0] pattern, input int width,
                                     input int state, input logic b);
        int   best;
        int   idx;
        logic ok;
        logic sj;
        best = 0;
        for (int l = 1; l < MAX_PATTERN_W; l++) begin
            if (l <= state + 1 && l < width) begin
                ok = 1'b1;
                for (int j = 0; j < l; j++) begin
                    idx = state + 1 - l + j;
                    sj  = (idx == state) ? b : pat_bit(pattern, width, idx);
                    if (pat_bit(pattern, width, j) != sj) ok = 1'b0;
                end
                if (ok) best = l;
            end
        end
        return best;
    endfunction

    function automatic int border(input logic [15:0] pattern, input int width);
        return fail_next(pattern, width, width - 1, pat_bit(pattern, width, width - 1));
    endfunction

endpackage

// File: rtl/seq_detect_mealy_sat_counter.sv
// Saturating event counter with a sticky full flag; clear has priority.
module sat_counter
    import seq_detect_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             sat
);

    localparam logic [CNT_W-1:0] FULL = '1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
            sat   <= 1'b0;
        end else if (clr) begin
            count <= '0;
            sat   <= 1'b0;
        end else if (inc && count != FULL) begin
            count <= count + 1'b1;
            if (count == FULL - 1'b1) sat <= 1'b1;
        end
    end

endmodule

// File: rtl/seq_detect_mealy.sv
// Mealy serial-pattern detector with runtime overlap selection, registered
// match copy and saturating match counter.
module seq_detect_mealy
    import seq_detect_pkg::*;
#(
    parameter int                   PATTERN_W = 4,
    parameter logic [PATTERN_W-1:0] PATTERN   = 4'b1010,
    parameter int                   CNT_W     = 8
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                en,
    input  logic                                din,
    input  logic                                overlap,
    input  logic                                clear_cnt,
    output logic                                match,
    output logic                                match_q,
    output logic [CNT_W-1:0]                    match_cnt,
    output logic                                cnt_sat,
    output logic [state_width(PATTERN_W)-1:0]   dbg_state
);

    localparam int               SW       = state_width(PATTERN_W);
    localparam logic [15:0]      PAT16    = 16'(PATTERN);
    localparam logic [SW-1:0]    LAST     = SW'(PATTERN_W - 1);
    localparam logic [SW-1:0]    BORDER   = SW'(border(PAT16, PATTERN_W));
    // EXP_BITS[k] is the bit expected while k bits are already matched.
    localparam logic [PATTERN_W-1:0] EXP_BITS = {<<{PATTERN}};

    logic [SW-1:0] state;
    logic [SW-1:0] state_d;
    logic [SW-1:0] next_tbl [2*PATTERN_W];
    mode_e         mode;

    for (genvar k = 0; k < PATTERN_W; k++) begin : g_state
        for (genvar b = 0; b < 2; b++) begin : g_bit
            localparam logic [SW-1:0] NXT = SW'(fail_next(PAT16, PATTERN_W, k, 1'(b)));
            assign next_tbl[2*k+b] = NXT;
        end
    end

    assign mode      = mode_e'(overlap);
    assign dbg_state = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= '0;
        else        state <= state_d;
    end

    always_comb begin
        state_d = state;
        match   = 1'b0;
        if (state > LAST) begin
            state_d = '0;
        end else if (en) begin
            if (state == LAST && din == EXP_BITS[LAST]) begin
                match   = reset;
                state_d = (mode == MODE_OVERLAP) ? BORDER : '0;
            end else begin
                state_d = next_tbl[{state, din}];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) match_q <= 1'b0;
        else        match_q <= match;
    end

    sat_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (match),
        .clr   (clear_cnt),
        .count (match_cnt),
        .sat   (cnt_sat)
    );

endmodule

// File: tb/tb_seq_detect_mealy.sv
// Bench for seq_detect_mealy: three configurations driven from shared inputs,
// checked against a sliding-window model, table vectors and corner sequences.
module tb_seq_detect_mealy;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic en = 1'b0, din = 1'b0, overlap = 1'b0, clear_cnt = 1'b0;

    logic       match_a, match_b, match_c;
    logic       mq_a, mq_b, mq_c;
    logic [7:0] cnt_a, cnt_b;
    logic [1:0] cnt_c;
    logic       sat_a, sat_b, sat_c;
    logic [1:0] st_a, st_b, st_c;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    seq_detect_mealy #(.PATTERN_W(4), .PATTERN(4'b1010), .CNT_W(8)) u_a (
        .clk(clk), .reset(reset), .en(en), .din(din), .overlap(overlap), .clear_cnt(clear_cnt),
        .match(match_a), .match_q(mq_a), .match_cnt(cnt_a), .cnt_sat(sat_a), .dbg_state(st_a));
    seq_detect_mealy #(.PATTERN_W(4), .PATTERN(4'b1101), .CNT_W(8)) u_b (
        .clk(clk), .reset(reset), .en(en), .din(din), .overlap(overlap), .clear_cnt(clear_cnt),
        .match(match_b), .match_q(mq_b), .match_cnt(cnt_b), .cnt_sat(sat_b), .dbg_state(st_b));
    seq_detect_mealy #(.PATTERN_W(4), .PATTERN(4'b1010), .CNT_W(2)) u_c (
        .clk(clk), .reset(reset), .en(en), .din(din), .overlap(overlap), .clear_cnt(clear_cnt),
        .match(match_c), .match_q(mq_c), .match_cnt(cnt_c), .cnt_sat(sat_c), .dbg_state(st_c));

    // Reference: a match is the last 4 bits received since the last restart
    // equalling the pattern; a non-overlapping match restarts the window.
    int pat [3]  = '{10, 13, 10};
    int cmax [3] = '{255, 255, 3};
    int hist [3];
    int hcnt [3];
    int mcnt [3];
    bit msat [3];
    bit mq [3];
    bit seen [3];
    logic exp_q [$];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int get_m(input int i);
        case (i)
            0: return int'(match_a);
            1: return int'(match_b);
            default: return int'(match_c);
        endcase
    endfunction

    function automatic int get_mq(input int i);
        case (i)
            0: return int'(mq_a);
            1: return int'(mq_b);
            default: return int'(mq_c);
        endcase
    endfunction

    function automatic int get_cnt(input int i);
        case (i)
            0: return int'(cnt_a);
            1: return int'(cnt_b);
            default: return int'(cnt_c);
        endcase
    endfunction

    function automatic int get_sat(input int i);
        case (i)
            0: return int'(sat_a);
            1: return int'(sat_b);
            default: return int'(sat_c);
        endcase
    endfunction

    function automatic bit model_match(input int i, input bit e, input bit d);
        return e && hcnt[i] >= 3 && ((((hist[i] << 1) | int'(d)) & 15) == pat[i]);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            hist[i] = 0; hcnt[i] = 0; mcnt[i] = 0; msat[i] = 1'b0; mq[i] = 1'b0;
        end
        exp_q.delete();
    endtask

    task automatic model_edge(input int i, input bit e, input bit d, input bit ov,
                              input bit cl, input bit m);
        if (e) begin
            if (m && !ov) begin
                hist[i] = 0;
                hcnt[i] = 0;
            end else begin
                hist[i] = ((hist[i] << 1) | int'(d)) & 16'hFFFF;
                if (hcnt[i] < 16) hcnt[i]++;
            end
        end
        mq[i] = m;
        if (cl) begin
            mcnt[i] = 0;
            msat[i] = 1'b0;
        end else if (m && mcnt[i] < cmax[i]) begin
            mcnt[i]++;
            if (mcnt[i] == cmax[i]) msat[i] = 1'b1;
        end
    endtask

    // Called just after a rising edge; returns just after the next one.
    task automatic step(input bit e, input bit d, input bit ov, input bit cl);
        bit m [3];
        en = e; din = d; overlap = ov; clear_cnt = cl;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            m[i] = model_match(i, e, d);
            seen[i] = get_m(i) != 0;
            chk($sformatf("match[%0d]", i), get_m(i), int'(m[i]));
        end
        exp_q.push_back(m[0]);
        @(posedge clk);
        for (int i = 0; i < 3; i++) model_edge(i, e, d, ov, cl, m[i]);
        #1;
        chk("match_q[0] vs queue", int'(mq_a), int'(exp_q.pop_front()));
        for (int i = 1; i < 3; i++) chk($sformatf("match_q[%0d]", i), get_mq(i), int'(mq[i]));
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("match_cnt[%0d]", i), get_cnt(i), mcnt[i]);
            chk($sformatf("cnt_sat[%0d]", i), get_sat(i), int'(msat[i]));
        end
    endtask

    // Asserts reset mid-cycle with inputs left as they are, so async clearing
    // of the Mealy output is observed before anything else changes.
    task automatic do_reset();
        reset = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst match[%0d]", i), get_m(i), 0);
            chk($sformatf("rst match_q[%0d]", i), get_mq(i), 0);
            chk($sformatf("rst cnt[%0d]", i), get_cnt(i), 0);
            chk($sformatf("rst sat[%0d]", i), get_sat(i), 0);
        end
        chk("rst state a", int'(st_a), 0);
        chk("rst state b", int'(st_b), 0);
        en = 1'b0; din = 1'b0; clear_cnt = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit rst;
        bit d;
        bit ov;
        bit exp_m;
        int exp_cnt;
    } vec_t;

    vec_t tbl [14];

    initial begin
        bit b;
        tbl[0]  = '{1, 1, 1, 0, 0};
        tbl[1]  = '{0, 0, 1, 0, 0};
        tbl[2]  = '{0, 1, 1, 0, 0};
        tbl[3]  = '{0, 0, 1, 1, 1};
        tbl[4]  = '{0, 1, 1, 0, 1};
        tbl[5]  = '{0, 0, 1, 1, 2};
        tbl[6]  = '{1, 1, 0, 0, 0};
        tbl[7]  = '{0, 0, 0, 0, 0};
        tbl[8]  = '{0, 1, 0, 0, 0};
        tbl[9]  = '{0, 0, 0, 1, 1};
        tbl[10] = '{0, 1, 0, 0, 1};
        tbl[11] = '{0, 0, 0, 0, 1};
        tbl[12] = '{0, 1, 0, 0, 1};
        tbl[13] = '{0, 0, 0, 1, 2};

        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // 1010 stream, overlapping then non-overlapping
        for (int k = 0; k < 14; k++) begin
            if (tbl[k].rst) do_reset();
            step(1'b1, tbl[k].d, tbl[k].ov, 1'b0);
            chk($sformatf("tbl[%0d] match", k), int'(seen[0]), int'(tbl[k].exp_m));
            chk($sformatf("tbl[%0d] cnt", k), int'(cnt_a), tbl[k].exp_cnt);
        end

        // 1101 failure path: 111 leaves two bits matched
        do_reset();
        step(1, 1, 1, 0); step(1, 1, 1, 0); step(1, 1, 1, 0);
        chk("b state after 111", int'(st_b), 2);
        step(1, 0, 1, 0);
        chk("b no match bit4", int'(seen[1]), 0);
        step(1, 1, 1, 0);
        chk("b match bit5", int'(seen[1]), 1);
        chk("b cnt", int'(cnt_b), 1);

        // qualifier gaps between every bit
        do_reset();
        for (int k = 0; k < 4; k++) begin
            b = (k % 2 == 0);
            step(1'b1, b, 1'b1, 1'b0);
            chk($sformatf("en gap qualified %0d", k), int'(seen[0]), int'(k == 3));
            step(1'b0, ~b, 1'b1, 1'b0);
            chk($sformatf("en gap idle %0d", k), int'(seen[0]), 0);
        end
        chk("en gap cnt", int'(cnt_a), 1);

        // CNT_W=2 saturation, then clear colliding with a match
        do_reset();
        for (int k = 0; k < 12; k++) step(1'b1, (k % 2 == 0), 1'b1, 1'b0);
        chk("c cnt saturated", int'(cnt_c), 3);
        chk("c sat set", int'(sat_c), 1);
        step(1, 1, 1, 0);
        step(1, 0, 1, 1);
        chk("c clear with match seen", int'(seen[2]), 1);
        chk("c cnt after clear", int'(cnt_c), 0);
        chk("c sat after clear", int'(sat_c), 0);

        // reset in the middle of a partial match
        do_reset();
        step(1, 1, 1, 0); step(1, 0, 1, 0); step(1, 1, 1, 0);
        en = 1'b1; din = 1'b0;
        do_reset();
        step(1, 0, 1, 0);
        chk("post reset lone 0", int'(seen[0]), 0);
        step(1, 1, 1, 0); step(1, 0, 1, 0); step(1, 1, 1, 0); step(1, 0, 1, 0);
        chk("post reset 1010", int'(seen[0]), 1);

        // random traffic
        do_reset();
        for (int k = 0; k < 600; k++) begin
            step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
